// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
// Module      : free_list
// Description : Circular FIFO of free physical register indices feeding the
//               rename stage. Rename reads the head (first-word-fall-through)
//               and pops it, the commit path pushes back freed registers, and
//               a flush restores the list to full so that it matches the
//               retirement RAT.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                 in   1              clock, rising edge
//   rst                 in   1              synchronous active-high reset
//   dequeue             in   1              rename pops the head entry
//   phys_reg            out  PHYS_REG_BITS  head entry (valid when not empty)
//   is_free_list_empty  out  1              list holds zero entries
//   enqueue             in   1              commit returns a freed register
//   enqueue_reg         in   PHYS_REG_BITS  register being freed
//   flush               in   1              restore the list to full
//   free_count          out  IDX_W+1        number of valid entries 0..DEPTH
// ============================================================================
module free_list #(
    parameter int PHYS_REG_BITS = 6,
    parameter int ARCH_REGS     = 32,
    // Must be a power of two: the pointers rely on natural modulo wrap.
    parameter int DEPTH         = 2**PHYS_REG_BITS - ARCH_REGS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dequeue,
    output logic [PHYS_REG_BITS-1:0]   phys_reg,
    output logic                       is_free_list_empty,
    input  logic                       enqueue,
    input  logic [PHYS_REG_BITS-1:0]   enqueue_reg,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     free_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // Reset image: head at index 0 wrap 0, tail at index 0 wrap 1 -> full.
    localparam logic [PTR_W-1:0] c_HEAD_RST = '0;
    localparam logic [PTR_W-1:0] c_TAIL_RST = {1'b1, {IDX_W{1'b0}}};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PHYS_REG_BITS-1:0] entry_q [DEPTH];
    logic [PTR_W-1:0]         head_q;
    logic [PTR_W-1:0]         head_d;
    logic [PTR_W-1:0]         tail_q;
    logic [PTR_W-1:0]         tail_d;

    logic                     w_empty;
    logic                     w_full;
    logic                     w_deq_ok;
    logic                     w_enq_ok;
    logic [IDX_W-1:0]         w_head_idx;
    logic [IDX_W-1:0]         w_tail_idx;

    assign w_head_idx = head_q[IDX_W-1:0];
    assign w_tail_idx = tail_q[IDX_W-1:0];

    assign w_empty = (head_q == tail_q);
    assign w_full  = (w_head_idx == w_tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

    // A flush cancels the rename-side pop in the same cycle.
    assign w_deq_ok = dequeue && !w_empty && !flush;

    // p0 backs x0 and is never reallocated, so a zero index is discarded.
    // When full, the enqueue is still accepted if a pop frees a slot in the
    // same cycle; when empty there is no bypass, so the pop is simply ignored.
    assign w_enq_ok = enqueue && (enqueue_reg != '0) && (!w_full || w_deq_ok);

    // ------------------------------------------------------------------------
    // Pointer next-state
    // ------------------------------------------------------------------------
    always_comb begin
        tail_d = tail_q;
        head_d = head_q;

        if (w_enq_ok) begin
            tail_d = tail_q + PTR_W'(1);
        end

        // Commit precedes the flush: the restored head is derived from the
        // post-enqueue tail, placed exactly DEPTH entries behind it.
        if (flush) begin
            head_d = {~tail_d[IDX_W], tail_d[IDX_W-1:0]};
        end else if (w_deq_ok) begin
            head_d = head_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= c_HEAD_RST;
            tail_q <= c_TAIL_RST;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // ------------------------------------------------------------------------
    // Entry storage; contents survive a flush untouched.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= PHYS_REG_BITS'(ARCH_REGS + i);
            end
        end else if (w_enq_ok) begin
            entry_q[w_tail_idx] <= enqueue_reg;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign phys_reg           = entry_q[w_head_idx];
    assign is_free_list_empty = w_empty;
    // Full pointer difference yields DEPTH when full thanks to the wrap bit.
    assign free_count         = tail_q - head_q;

    // Pushing into a full list without a simultaneous pop is a protocol error.
    a_no_enqueue_when_full : assert property (
        @(posedge clk) disable iff (rst)
        !(enqueue && w_full && !w_deq_ok)
    );

endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
// Module      : tb_free_list
// Description : Self-checking bench for free_list. A queue-level reference
//               model (ring storage plus unbounded head/tail counters) gives
//               the expected head, emptiness and occupancy each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_free_list;

    localparam int c_PRB   = 6;
    localparam int c_ARCH  = 32;
    localparam int c_DEPTH = 32;

    logic             clk;
    logic             rst;
    logic             dequeue;
    logic [c_PRB-1:0] phys_reg;
    logic             is_free_list_empty;
    logic             enqueue;
    logic [c_PRB-1:0] enqueue_reg;
    logic             flush;
    logic [5:0]       free_count;

    free_list #(
        .PHYS_REG_BITS (c_PRB),
        .ARCH_REGS     (c_ARCH),
        .DEPTH         (c_DEPTH)
    ) u_dut (
        .clk                (clk),
        .rst                (rst),
        .dequeue            (dequeue),
        .phys_reg           (phys_reg),
        .is_free_list_empty (is_free_list_empty),
        .enqueue            (enqueue),
        .enqueue_reg        (enqueue_reg),
        .flush              (flush),
        .free_count         (free_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: storage slots plus ever-increasing head/tail counts.
    int m_mem [c_DEPTH];
    int m_head;
    int m_tail;

    function automatic int m_count();
        return m_tail - m_head;
    endfunction

    function automatic int m_front();
        return m_mem[m_head % c_DEPTH];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < c_DEPTH; i++) m_mem[i] = c_ARCH + i;
        m_head = 0;
        m_tail = c_DEPTH;
    endtask

    task automatic do_reset();
        rst = 1'b1; dequeue = 1'b0; enqueue = 1'b0; enqueue_reg = '0; flush = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    // One clock with the given inputs; the model advances at the same edge.
    task automatic cycle(input logic d, input logic e, input logic [c_PRB-1:0] r, input logic f);
        bit deq_ok, enq_ok;
        dequeue = d; enqueue = e; enqueue_reg = r; flush = f;
        deq_ok = d && (m_count() != 0) && !f;
        enq_ok = e && (r != 0) && ((m_count() != c_DEPTH) || deq_ok);
        @(posedge clk);
        if (enq_ok) begin
            m_mem[m_tail % c_DEPTH] = int'(r);
            m_tail++;
        end
        if (f) m_head = m_tail - c_DEPTH;
        else if (deq_ok) m_head++;
        #1;
        dequeue = 1'b0; enqueue = 1'b0; enqueue_reg = '0; flush = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (free_count !== 6'd32) begin
            n_fail++; $display("FAIL reset_count: got %0d want 32", free_count);
        end
        n_tests++;
        if (is_free_list_empty !== 1'b0) begin
            n_fail++; $display("FAIL reset_empty: got %0b want 0", is_free_list_empty);
        end
        n_tests++;
        if (phys_reg !== 6'd32) begin
            n_fail++; $display("FAIL reset_head: got %0d want 32", phys_reg);
        end
    endtask

    task automatic test_drain();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            n_tests++;
            if (int'(phys_reg) !== c_ARCH + i) begin
                n_fail++; $display("FAIL drain_order[%0d]: got %0d want %0d", i, phys_reg, c_ARCH + i);
            end
            cycle(1'b1, 1'b0, '0, 1'b0);
        end
        n_tests++;
        if (is_free_list_empty !== 1'b1 || free_count !== 6'd0) begin
            n_fail++; $display("FAIL drain_empty: got empty=%0b count=%0d want 1/0", is_free_list_empty, free_count);
        end
        cycle(1'b1, 1'b0, '0, 1'b0);
        n_tests++;
        if (is_free_list_empty !== 1'b1 || free_count !== 6'd0) begin
            n_fail++; $display("FAIL deq_when_empty: got empty=%0b count=%0d want 1/0", is_free_list_empty, free_count);
        end
    endtask

    // Continues from the drained state left by test_drain.
    task automatic test_enq_empty();
        cycle(1'b1, 1'b1, 6'd40, 1'b0);
        n_tests++;
        if (free_count !== 6'd1 || phys_reg !== 6'd40 || is_free_list_empty !== 1'b0) begin
            n_fail++; $display("FAIL enq_empty: got count=%0d head=%0d empty=%0b want 1/40/0",
                               free_count, phys_reg, is_free_list_empty);
        end
    endtask

    task automatic test_full_swap();
        do_reset();
        cycle(1'b1, 1'b1, 6'd45, 1'b0);
        n_tests++;
        if (free_count !== 6'd32 || phys_reg !== 6'd33) begin
            n_fail++; $display("FAIL full_swap: got count=%0d head=%0d want 32/33", free_count, phys_reg);
        end
        for (int i = 0; i < 32; i++) begin
            int exp_v;
            exp_v = (i < 31) ? 33 + i : 45;
            n_tests++;
            if (int'(phys_reg) !== exp_v) begin
                n_fail++; $display("FAIL wrap_order[%0d]: got %0d want %0d", i, phys_reg, exp_v);
            end
            cycle(1'b1, 1'b0, '0, 1'b0);
        end
    endtask

    task automatic test_zero_drop();
        do_reset();
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, 6'd0, 1'b0);
        n_tests++;
        if (free_count !== 6'd31 || phys_reg !== 6'd33) begin
            n_fail++; $display("FAIL zero_drop: got count=%0d head=%0d want 31/33", free_count, phys_reg);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, '0, 1'b0);
        n_tests++;
        if (free_count !== 6'd22 || phys_reg !== 6'd42) begin
            n_fail++; $display("FAIL pre_flush: got count=%0d head=%0d want 22/42", free_count, phys_reg);
        end
        // Enqueue of 50 lands in slot 0; restored head sits just after it.
        cycle(1'b1, 1'b1, 6'd50, 1'b1);
        n_tests++;
        if (free_count !== 6'd32 || is_free_list_empty !== 1'b0) begin
            n_fail++; $display("FAIL flush_full: got count=%0d empty=%0b want 32/0", free_count, is_free_list_empty);
        end
        for (int i = 0; i < 32; i++) begin
            int exp_v;
            exp_v = (i < 31) ? 33 + i : 50;
            n_tests++;
            if (int'(phys_reg) !== exp_v) begin
                n_fail++; $display("FAIL flush_order[%0d]: got %0d want %0d", i, phys_reg, exp_v);
            end
            cycle(1'b1, 1'b0, '0, 1'b0);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic d, e, f;
            logic [c_PRB-1:0] r;
            int phase;
            phase = (c / 150) % 3;
            // Phases bias toward draining, refilling, or balanced traffic.
            d = ($urandom_range(0, 99) < ((phase == 0) ? 85 : (phase == 1) ? 25 : 55));
            e = ($urandom_range(0, 99) < ((phase == 0) ? 25 : (phase == 1) ? 85 : 55));
            r = ($urandom_range(0, 9) == 0) ? 6'd0 : c_PRB'($urandom_range(1, 63));
            f = ($urandom_range(0, 79) == 0);
            // Never push into a full list unless a pop frees a slot.
            if (m_count() == c_DEPTH && !(d && !f)) e = 1'b0;
            cycle(d, e, r, f);
            n_tests++;
            if (int'(free_count) !== m_count() || is_free_list_empty !== (m_count() == 0)) begin
                n_fail++; $display("FAIL rand_state[%0d]: got count=%0d empty=%0b want %0d/%0b",
                                   c, free_count, is_free_list_empty, m_count(), (m_count() == 0));
            end
            if (m_count() != 0) begin
                n_tests++;
                if (int'(phys_reg) !== m_front()) begin
                    n_fail++; $display("FAIL rand_head[%0d]: got %0d want %0d", c, phys_reg, m_front());
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        // Drive pointers past the wrap point before resetting.
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, (m_count() < c_DEPTH), c_PRB'($urandom_range(1, 63)), 1'b0);
        end
        do_reset();
        n_tests++;
        if (free_count !== 6'd32 || phys_reg !== 6'd32 || is_free_list_empty !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: got count=%0d head=%0d empty=%0b want 32/32/0",
                               free_count, phys_reg, is_free_list_empty);
        end
        for (int i = 0; i < 32; i++) begin
            n_tests++;
            if (int'(phys_reg) !== c_ARCH + i) begin
                n_fail++; $display("FAIL reset_mid_order[%0d]: got %0d want %0d", i, phys_reg, c_ARCH + i);
            end
            cycle(1'b1, 1'b0, '0, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; dequeue = 1'b0; enqueue = 1'b0; enqueue_reg = '0; flush = 1'b0;
        model_reset();
        test_reset();
        test_drain();
        test_enq_empty();
        test_full_swap();
        test_zero_drop();
        test_flush();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
